shift_reg_ctrl: RTL
===================

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001: Parameter WIDTH, default 4, SHALL set the deserialized word width (legal range 2..32).
REQ-002: Parameter MSB_FIRST, default 1, SHALL select shift direction: 1 = first bit lands in word MSB, 0 = first bit lands in LSB.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004: reset  input  1  SHALL be the synchronous, active-high reset, sampled on posedge clk.
REQ-005: x_i  input  1  SHALL be the serial data bit.
REQ-006: x_valid_i  input  1  SHALL qualify x_i.
REQ-007: x_ready_o  output  1  SHALL indicate the block accepts x_i this cycle.
REQ-008: flush_i  input  1  SHALL discard any partially collected word.
REQ-009: word_o  output  WIDTH  SHALL carry the assembled parallel word.
REQ-010: word_valid_o  output  1  SHALL qualify word_o.
REQ-011: word_ready_i  input  1  SHALL indicate the consumer takes word_o this cycle.
REQ-012: bit_cnt_o  output  $clog2(WIDTH)+1  SHALL report bits collected in the current partial word.

Function
REQ-013: A bit SHALL be accepted when x_valid_i && x_ready_o at posedge clk; no other bit is shifted.
REQ-014: On accept, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], x_i}; MSB_FIRST=0: sr <= {x_i, sr[WIDTH-1:1]}.
REQ-015: bit_cnt_o SHALL increment by 1 per accepted bit, range 0..WIDTH-1; accepting the WIDTH-th bit SHALL wrap it to 0.
REQ-016: Accepting the WIDTH-th bit SHALL load word_o with the completed shift value (including that bit) and set word_valid_o on the next cycle (latency 1 cycle from last bit).
REQ-017: Output slot FSM states: EMPTY (word_valid_o=0) and FULL (word_valid_o=1).
REQ-018: EMPTY -> FULL on word completion; FULL -> EMPTY on word_ready_i with no completion that cycle; FULL stays FULL when word_ready_i and a completion coincide (word_o reloaded with new word, no bubble).
REQ-019: In FULL without word_ready_i, word_o and word_valid_o SHALL hold stable.
REQ-020: word_ready_i in EMPTY SHALL have no effect.
REQ-021: x_ready_o SHALL be 0 only when bit_cnt_o == WIDTH-1 and state FULL and word_ready_i == 0; otherwise 1 (the block shifts the next word while one is pending).
REQ-022: x_ready_o MAY depend combinationally on word_ready_i; it SHALL NOT depend on x_valid_i or x_i.
REQ-023: flush_i SHALL clear bit_cnt_o and sr to 0 next cycle; any bit offered in the same cycle SHALL be dropped (x_ready_o is 0 while flush_i is 1); the output slot is unaffected.
REQ-024: word_o bits not yet loaded since reset SHALL read 0; no partial word SHALL ever appear on word_o.
REQ-025: No data loss: every accepted bit appears in exactly one delivered word unless flushed or reset.

Reset
REQ-026: reset SHALL take priority over all inputs including flush_i.
REQ-027: After reset: sr = 0, bit_cnt_o = 0, word_o = 0, word_valid_o = 0, state EMPTY, x_ready_o = 1 once reset deasserts.
REQ-028: reset mid-word or with FULL slot SHALL discard the partial word and pending word without emitting either.

Verification
REQ-029: WIDTH=4, MSB_FIRST=1, word_ready_i=1, bits 1,0,1,1 on consecutive cycles -> word_o=4'b1011, word_valid_o=1 for exactly one cycle, the cycle after the 4th bit.
REQ-030: MSB_FIRST=0, same bits -> word_o=4'b1101.
REQ-031: word_ready_i=0, stream 8 bits 1,1,1,1,0,0,1,0 continuously -> first word 4'b1111 held; x_ready_o=0 at bit_cnt_o=3; raising word_ready_i -> 4'b1111 taken, then 4'b0010 delivered; no bit lost.
REQ-032: Completion and word_ready_i in same cycle -> word_valid_o stays 1, word_o changes to new word with no idle cycle.
REQ-033: After 2 bits, assert flush_i with x_valid_i=1 -> bit_cnt_o=0, flushed bits absent from next word; pending FULL word unaffected.
REQ-034: reset asserted with bit_cnt_o=3 and state FULL -> next cycle all outputs 0 except x_ready_o=1; following 4 bits 0,1,0,1 -> word_o=4'b0101.

Source files
------------

// File: rtl/shift_reg_ctrl.sv
// Serial-to-parallel deserializer with a one-word output slot.
// The next word keeps shifting in while the slot holds a word that has not yet been consumed.
module shift_reg_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       x_i,
  input  logic                       x_valid_i,
  output logic                       x_ready_o,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           word_o,
  output logic                       word_valid_o,
  input  logic                       word_ready_i,
  output logic [$clog2(WIDTH):0]     bit_cnt_o
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_sr;
  logic [WIDTH-1:0]  r_word;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  w_shift;
  logic              w_accept;
  logic              w_last;

  assign w_shift = MSB_FIRST ? {r_sr[WIDTH-2:0], x_i} : {x_i, r_sr[WIDTH-1:1]};

  always_comb begin
    // The final bit is blocked only when the slot would still be occupied at the completing edge.
    x_ready_o   = !flush_i && !((r_cnt == LAST) && (r_state == FULL) && !word_ready_i);
    w_accept    = x_valid_i && x_ready_o;
    w_last      = w_accept && (r_cnt == LAST);
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_last) w_state_nxt = FULL;
      FULL:  if (word_ready_i && !w_last) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush_i) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_sr  <= w_shift;
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
      if (w_last) r_word <= w_shift;
    end
  end

  assign word_o       = r_word;
  assign word_valid_o = (r_state == FULL);
  assign bit_cnt_o    = r_cnt;

endmodule
